lv_lbist_seq: RTL and testbench

Parametrised LV logic-BIST sequencer. It runs CH_NUM self-test channels one after another; each channel is a req/ack/err handshake target such as the scan-register checker or the watchdog OWT link. Each channel issues a configurable number of requests, counts good acknowledges against a per-channel pass threshold, and applies a per-request timeout. It reports per-channel and aggregate fail plus a done pulse to the LV top-level safety logic.

---
 rtl/lv_lbist_seq_if.sv | 11 +
 rtl/lv_lbist_seq.sv | 173 +++++++++++++++++
 tb/tb_lv_lbist_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lv_lbist_seq_if.sv
// rtl/lv_lbist_seq_if.sv - req/ack/err handshake bundle between the LBIST sequencer and its test channels
interface lv_lbist_seq_if #(
   parameter int CH_NUM = 2
);
   logic [CH_NUM-1:0] ch_req;
   logic [CH_NUM-1:0] ch_ack;
   logic [CH_NUM-1:0] ch_err;

   modport master (output ch_req, input ch_ack, input ch_err);
   modport slave  (input ch_req, output ch_ack, output ch_err);
endinterface

// File: rtl/lv_lbist_seq.sv
// rtl/lv_lbist_seq.sv - LV logic-BIST sequencer running CH_NUM req/ack test channels in order
module lv_lbist_seq #(
   parameter int CH_NUM  = 2,
   parameter int CNT_W   = 4,
   parameter int TMO_CYC = 1000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_bist_en,
   input  logic [CH_NUM*CNT_W-1:0] i_ch_req_num,
   input  logic [CH_NUM*CNT_W-1:0] i_ch_ok_th,
   lv_lbist_seq_if.master          ch_if,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_fail,
   output logic [CH_NUM-1:0]       o_ch_fail,
   output logic                    o_tmo
);
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CH_NUM - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [CNT_W-1:0]   req_num_q [CH_NUM];
   logic [CNT_W-1:0]   req_num_d [CH_NUM];
   logic [CNT_W-1:0]   ok_th_q [CH_NUM];
   logic [CNT_W-1:0]   ok_th_d [CH_NUM];
   logic [CH_NUM-1:0]  ch_req_q, ch_req_d;
   logic [CH_NUM-1:0]  ch_fail_q, ch_fail_d;
   logic               tmo_q, tmo_d;
   logic               fail_q, fail_d;
   logic               done_q, done_d;
   logic               run_active;

   assign run_active = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_NEXT);

   // State and datapath registers; config is only written in IDLE so it stays frozen for the run
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         req_cnt_q <= '0;
         ok_cnt_q  <= '0;
         tmo_cnt_q <= '0;
         ch_req_q  <= '0;
         ch_fail_q <= '0;
         tmo_q     <= 1'b0;
         fail_q    <= 1'b0;
         done_q    <= 1'b0;
         for (int k = 0; k < CH_NUM; k++) begin
            req_num_q[k] <= '0;
            ok_th_q[k]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         req_cnt_q <= req_cnt_d;
         ok_cnt_q  <= ok_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         ch_req_q  <= ch_req_d;
         ch_fail_q <= ch_fail_d;
         tmo_q     <= tmo_d;
         fail_q    <= fail_d;
         done_q    <= done_d;
         req_num_q <= req_num_d;
         ok_th_q   <= ok_th_d;
      end
   end

   // Next-state and next-value logic; abort overrides every in-run decision
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      req_cnt_d = req_cnt_q;
      ok_cnt_d  = ok_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      ch_req_d  = ch_req_q;
      ch_fail_d = ch_fail_q;
      tmo_d     = tmo_q;
      fail_d    = fail_q;
      done_d    = 1'b0;
      req_num_d = req_num_q;
      ok_th_d   = ok_th_q;

      case (state_q)
         S_IDLE: begin
            if (i_bist_en) begin
               for (int k = 0; k < CH_NUM; k++) begin
                  req_num_d[k] = i_ch_req_num[k*CNT_W +: CNT_W];
                  ok_th_d[k]   = i_ch_ok_th[k*CNT_W +: CNT_W];
               end
               ch_fail_d = '0;
               tmo_d     = 1'b0;
               fail_d    = 1'b0;
               idx_d     = '0;
               state_d   = (i_ch_req_num[CNT_W-1:0] == '0) ? S_NEXT : S_REQ;
            end
         end
         S_REQ: begin
            ch_req_d        = '0;
            ch_req_d[idx_q] = 1'b1;
            tmo_cnt_d       = '0;
            state_d         = S_WAIT;
         end
         S_WAIT: begin
            if (ch_if.ch_ack[idx_q]) begin
               // An ack in the final timeout cycle still counts as a normal ack
               ch_req_d  = '0;
               req_cnt_d = req_cnt_q + 1'b1;
               if (!ch_if.ch_err[idx_q]) begin
                  ok_cnt_d = ok_cnt_q + 1'b1;
               end
               state_d = (req_cnt_q + 1'b1 == req_num_q[idx_q]) ? S_NEXT : S_REQ;
            end else if (tmo_cnt_q == TMO_LAST) begin
               ch_req_d         = '0;
               ch_fail_d[idx_q] = 1'b1;
               tmo_d            = 1'b1;
               state_d          = S_NEXT;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            if (ok_cnt_q < ok_th_q[idx_q]) begin
               ch_fail_d[idx_q] = 1'b1;
            end
            req_cnt_d = '0;
            ok_cnt_d  = '0;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               fail_d  = |ch_fail_d;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = (req_num_q[idx_d] == '0) ? S_NEXT : S_REQ;
            end
         end
         S_DONE: begin
            if (!i_bist_en) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (run_active && !i_bist_en) begin
         state_d   = S_IDLE;
         idx_d     = '0;
         req_cnt_d = '0;
         ok_cnt_d  = '0;
         tmo_cnt_d = '0;
         ch_req_d  = '0;
         ch_fail_d = '0;
         tmo_d     = 1'b0;
         fail_d    = 1'b0;
         done_d    = 1'b0;
      end
   end

   assign ch_if.ch_req = ch_req_q;
   assign o_busy       = run_active;
   assign o_done       = done_q;
   assign o_fail       = fail_q;
   assign o_ch_fail    = ch_fail_q;
   assign o_tmo        = tmo_q;
endmodule

// File: tb/tb_lv_lbist_seq.sv
// tb/tb_lv_lbist_seq.sv - bench for lv_lbist_seq with a randomised channel responder
module tb_lv_lbist_seq;
   localparam int CH    = 2;
   localparam int CW    = 4;
   localparam int TMO   = 8;
   localparam int NEVER = 99;
   localparam int MAXR  = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [CH*CW-1:0] req_num_in;
   logic [CH*CW-1:0] ok_th_in;
   logic             o_busy, o_done, o_fail, o_tmo;
   logic [CH-1:0]    o_ch_fail;

   lv_lbist_seq_if #(.CH_NUM(CH)) ch_if ();

   lv_lbist_seq #(.CH_NUM(CH), .CNT_W(CW), .TMO_CYC(TMO)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_bist_en    (en),
      .i_ch_req_num (req_num_in),
      .i_ch_ok_th   (ok_th_in),
      .ch_if        (ch_if.master),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_fail       (o_fail),
      .o_ch_fail    (o_ch_fail),
      .o_tmo        (o_tmo)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int cfg_req [CH];
   int cfg_th  [CH];
   int plan_lat [CH][MAXR];
   bit plan_err [CH][MAXR];
   bit stray_en;
   int gen;

   int seen_gen;
   int pulses [CH];
   int max_hi [CH];
   int hi_cnt [CH];
   int cur    [CH];
   int rq     [CH];
   bit prev_req [CH];
   int done_cnt;
   int onehot_bad;

   // Channel responder and monitor: acks each request after its planned number of high cycles
   initial begin
      logic [CH-1:0] ack_v, err_v;
      seen_gen = 0; done_cnt = 0; onehot_bad = 0;
      for (int k = 0; k < CH; k++) begin
         pulses[k] = 0; max_hi[k] = 0; hi_cnt[k] = 0; cur[k] = 0; rq[k] = 0; prev_req[k] = 1'b0;
      end
      ch_if.ch_ack = '0;
      ch_if.ch_err = '0;
      forever begin
         @(negedge clk);
         if (gen != seen_gen) begin
            seen_gen = gen;
            for (int k = 0; k < CH; k++) begin
               pulses[k] = 0; max_hi[k] = 0; rq[k] = 0;
            end
            done_cnt = 0; onehot_bad = 0;
         end
         if ($countones(ch_if.ch_req) > 1) onehot_bad++;
         if (o_done) done_cnt++;
         ack_v = '0;
         err_v = '0;
         for (int k = 0; k < CH; k++) begin
            if (ch_if.ch_req[k]) begin
               if (!prev_req[k]) begin
                  hi_cnt[k] = 0;
                  cur[k] = rq[k];
                  if (rq[k] < MAXR - 1) rq[k]++;
                  pulses[k]++;
               end else begin
                  hi_cnt[k]++;
               end
               if (hi_cnt[k] + 1 > max_hi[k]) max_hi[k] = hi_cnt[k] + 1;
               ack_v[k] = (hi_cnt[k] == plan_lat[k][cur[k]]);
               err_v[k] = ack_v[k] ? plan_err[k][cur[k]] : 1'($urandom_range(0, 1));
            end else begin
               ack_v[k] = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
               err_v[k] = 1'($urandom_range(0, 1));
            end
            prev_req[k] = ch_if.ch_req[k];
         end
         ch_if.ch_ack = ack_v;
         ch_if.ch_err = err_v;
      end
   end

   task automatic set_plan(input int lat, input bit err);
      for (int k = 0; k < CH; k++)
         for (int r = 0; r < MAXR; r++) begin
            plan_lat[k][r] = lat;
            plan_err[k][r] = err;
         end
   endtask

   task automatic drive_cfg();
      for (int k = 0; k < CH; k++) begin
         req_num_in[k*CW +: CW] = CW'(cfg_req[k]);
         ok_th_in[k*CW +: CW]   = CW'(cfg_th[k]);
      end
   endtask

   // Runs one complete BIST pass and checks it against a cycle-cost model of the channel plans
   task automatic run_case(input string nm);
      int e_edges, n, ok;
      bit got, t;
      logic [CH-1:0] e_fail;
      bit e_tmo;
      int e_pulses [CH];
      int e_maxhi [CH];
      e_edges = 0; e_fail = '0; e_tmo = 1'b0;
      for (int k = 0; k < CH; k++) begin
         e_edges += 1;
         ok = 0; t = 1'b0; e_pulses[k] = 0; e_maxhi[k] = 0;
         for (int r = 0; r < cfg_req[k]; r++) begin
            e_pulses[k]++;
            e_edges += 1;
            if (plan_lat[k][r] >= TMO) begin
               e_edges += TMO;
               if (TMO > e_maxhi[k]) e_maxhi[k] = TMO;
               t = 1'b1;
               break;
            end
            e_edges += plan_lat[k][r] + 1;
            if (plan_lat[k][r] + 1 > e_maxhi[k]) e_maxhi[k] = plan_lat[k][r] + 1;
            if (!plan_err[k][r]) ok++;
         end
         e_fail[k] = t || (ok < cfg_th[k]);
         e_tmo = e_tmo | t;
      end

      @(negedge clk);
      gen++;
      drive_cfg();
      en = 1'b1;
      n = 0; got = 1'b0;
      while (!got && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            req_num_in = (CH*CW)'($urandom);
            ok_th_in   = (CH*CW)'($urandom);
         end
         if (o_done) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s done_seen: got=0 want=1", nm);
      end else begin
         total++;
         if (n !== e_edges + 1) begin bad++; $display("FAIL %s done_latency: got=%0d want=%0d", nm, n, e_edges + 1); end
         total++;
         if (o_ch_fail !== e_fail) begin bad++; $display("FAIL %s ch_fail: got=%b want=%b", nm, o_ch_fail, e_fail); end
         total++;
         if (o_fail !== (|e_fail)) begin bad++; $display("FAIL %s fail: got=%b want=%b", nm, o_fail, |e_fail); end
         total++;
         if (o_tmo !== e_tmo) begin bad++; $display("FAIL %s tmo: got=%b want=%b", nm, o_tmo, e_tmo); end
         total++;
         if (o_busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got=%b want=0", nm, o_busy); end
      end
      @(negedge clk);
      total++;
      if (o_done !== 1'b0) begin bad++; $display("FAIL %s done_width: got=%b want=0", nm, o_done); end
      @(negedge clk);
      total++;
      if (done_cnt !== 1) begin bad++; $display("FAIL %s done_count: got=%0d want=1", nm, done_cnt); end
      total++;
      if (onehot_bad !== 0) begin bad++; $display("FAIL %s req_onehot: got=%0d want=0", nm, onehot_bad); end
      for (int k = 0; k < CH; k++) begin
         total++;
         if (pulses[k] !== e_pulses[k]) begin bad++; $display("FAIL %s pulses_ch%0d: got=%0d want=%0d", nm, k, pulses[k], e_pulses[k]); end
         total++;
         if (max_hi[k] !== e_maxhi[k]) begin bad++; $display("FAIL %s req_high_ch%0d: got=%0d want=%0d", nm, k, max_hi[k], e_maxhi[k]); end
      end
      en = 1'b0;
      @(negedge clk);
      total++;
      if (o_ch_fail !== e_fail || o_busy !== 1'b0) begin
         bad++; $display("FAIL %s held_in_idle: got=%b/%b want=%b/0", nm, o_ch_fail, o_busy, e_fail);
      end
   endtask

   task automatic check_all_zero(input string nm);
      total++;
      if ({ch_if.ch_req, o_busy, o_done, o_fail, o_ch_fail, o_tmo} !== '0) begin
         bad++;
         $display("FAIL %s outputs: got req=%b busy=%b done=%b fail=%b ch_fail=%b tmo=%b want all 0",
                  nm, ch_if.ch_req, o_busy, o_done, o_fail, o_ch_fail, o_tmo);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset_held");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_released");
   endtask

   task automatic test_basic();
      set_plan(0, 1'b0);
      cfg_req = '{4, 1}; cfg_th = '{3, 1};
      run_case("basic");
      cfg_req = '{1, 1}; cfg_th = '{1, 1};
      run_case("min_run");
   endtask

   task automatic test_err();
      set_plan(0, 1'b0);
      plan_err[0][0] = 1'b1; plan_err[0][2] = 1'b1;
      cfg_req = '{4, 1}; cfg_th = '{3, 1};
      run_case("err_two_of_four");
   endtask

   task automatic test_timeout();
      set_plan(0, 1'b0);
      plan_lat[1][0] = NEVER;
      cfg_req = '{1, 2}; cfg_th = '{1, 1};
      run_case("ch1_timeout");
   endtask

   task automatic test_ack_at_tmo();
      set_plan(0, 1'b0);
      plan_lat[0][0] = TMO - 1; plan_lat[0][2] = 2;
      plan_lat[1][0] = 1;       plan_lat[1][1] = TMO - 1;
      cfg_req = '{3, 2}; cfg_th = '{3, 2};
      stray_en = 1'b1;
      run_case("ack_in_tmo_cycle_stray");
      stray_en = 1'b0;
   endtask

   task automatic test_abort();
      int n;
      set_plan(0, 1'b0);
      plan_lat[0][1] = NEVER;
      cfg_req = '{4, 1}; cfg_th = '{3, 1};
      @(negedge clk);
      gen++;
      drive_cfg();
      en = 1'b1;
      n = 0;
      while (!(ch_if.ch_req[0] && pulses[0] == 2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 100) begin bad++; $display("FAIL abort_reach_wait: got=timeout want=second request"); end
      repeat (2) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check_all_zero("abort_next_cycle");
      repeat (4) @(negedge clk);
      total++;
      if (done_cnt !== 0) begin bad++; $display("FAIL abort_no_done: got=%0d want=0", done_cnt); end
      set_plan(1, 1'b0);
      cfg_req = '{2, 3}; cfg_th = '{2, 2};
      run_case("abort_rerun");
   endtask

   task automatic test_zero_req();
      set_plan(0, 1'b0);
      cfg_req = '{0, 2}; cfg_th = '{0, 1};
      run_case("zero_req_th0");
      cfg_th = '{1, 1};
      run_case("zero_req_th1");
   endtask

   task automatic test_async_reset();
      int n;
      set_plan(NEVER, 1'b0);
      cfg_req = '{1, 2}; cfg_th = '{1, 1};
      @(negedge clk);
      gen++;
      drive_cfg();
      en = 1'b1;
      n = 0;
      while (!ch_if.ch_req[1] && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 100 || o_tmo !== 1'b1) begin
         bad++; $display("FAIL async_reset_setup: got n=%0d tmo=%b want ch1 waiting with tmo=1", n, o_tmo);
      end
      #2;
      rst_n = 1'b0;
      en = 1'b0;
      #1;
      check_all_zero("async_reset_immediate");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("async_reset_after");
   endtask

   task automatic test_random();
      int sel;
      for (int it = 0; it < 20; it++) begin
         for (int k = 0; k < CH; k++) begin
            cfg_req[k] = $urandom_range(0, 5);
            cfg_th[k]  = $urandom_range(0, 5);
            for (int r = 0; r < MAXR; r++) begin
               sel = $urandom_range(0, 11);
               if (sel < 8)       plan_lat[k][r] = $urandom_range(0, 3);
               else if (sel < 10) plan_lat[k][r] = TMO - 1;
               else               plan_lat[k][r] = NEVER;
               plan_err[k][r] = ($urandom_range(0, 2) == 0);
            end
         end
         stray_en = 1'($urandom_range(0, 1));
         run_case($sformatf("random_%0d", it));
      end
      stray_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      stray_en = 1'b0;
      gen = 0;
      req_num_in = '0;
      ok_th_in = '0;
      set_plan(0, 1'b0);
      test_reset();
      test_basic();
      test_err();
      test_timeout();
      test_ack_at_tmo();
      test_abort();
      test_zero_req();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
